hilo_mdu: RTL and testbench

//  E-stage multiply/divide unit; the producer side of the HI/LO register interface.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/hilo_mdu_div_iter.sv | 83 ++++++++
 rtl/hilo_mdu.sv | 214 +++++++++++++++++++++
 tb/tb_hilo_mdu.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

    localparam int MDU_W     = 32;
    localparam int DIV_ITERS = MDU_W;

    // Operation select presented on the E-stage op bus.
    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } mdu_op_t;

    // Sequencing states for the iterative divide path.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/hilo_mdu_div_iter.sv
// Radix-2 restoring divider core: one quotient bit per step on unsigned operands.
// quotient/remainder present the result of the step currently being taken, so
// they are final exactly while done is high.
module div_iter #(
    parameter int W         = 32,
    parameter int DIV_ITERS = W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    input  logic         step,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         done
);

    localparam int CW = $clog2(DIV_ITERS + 1);

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [W:0]    rem_shift_s;
    logic [W:0]    diff_s;
    logic [W-1:0]  rem_next_s;
    logic [W-1:0]  quo_next_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift_s = {rem_q, quo_q[W-1]};
        diff_s      = rem_shift_s - {1'b0, dvs_q};
        if (diff_s[W] == 1'b0) begin
            rem_next_s = diff_s[W-1:0];
            quo_next_s = {quo_q[W-2:0], 1'b1};
        end else begin
            rem_next_s = rem_shift_s[W-1:0];
            quo_next_s = {quo_q[W-2:0], 1'b0};
        end
    end

    // Load operands on start, otherwise advance one step when enabled.
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (start) begin
            rem_d = {W{1'b0}};
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = {CW{1'b0}};
        end else if (step) begin
            rem_d = rem_next_s;
            quo_d = quo_next_s;
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= {W{1'b0}};
            quo_q <= {W{1'b0}};
            dvs_q <= {W{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign done      = step && (cnt_q == CW'(DIV_ITERS - 1));
    assign quotient  = quo_next_s;
    assign remainder = rem_next_s;

endmodule

// File: rtl/hilo_mdu.sv
// E-stage multiply/divide unit producing the {HI,LO} write for the HI/LO register.
// Multiplies and MT* moves complete in the issue cycle; divides run on the
// iterative core and present a registered result in DONE.
module hilo_mdu #(
    parameter int W         = 32,
    parameter int DIV_ITERS = W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           e_valid,
    input  logic [2:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [2*W-1:0] hilo_i,
    input  logic           flush,
    input  logic           stall_i,
    output logic           stall_o,
    output logic           we_o,
    output logic [2*W-1:0] hilo_o
);

    import mdu_pkg::*;

    mdu_state_t     state_q, state_d;
    logic [2*W-1:0] res_q, res_d;
    logic           negq_q, negq_d;
    logic           negr_q, negr_d;

    logic [2*W-1:0] mul_signed_s;
    logic [2*W-1:0] mul_unsigned_s;
    logic           is_signed_s;
    logic           a_neg_s;
    logic           b_neg_s;
    logic [W-1:0]   dividend_s;
    logic [W-1:0]   divisor_s;
    logic [W-1:0]   quo_fix_s;
    logic [W-1:0]   rem_fix_s;

    logic           div_start_s;
    logic           div_step_s;
    logic           div_done_s;
    logic [W-1:0]   div_quo_s;
    logic [W-1:0]   div_rem_s;

    logic           stall_s;
    logic           we_s;
    logic [2*W-1:0] hilo_s;

    assign mul_signed_s   = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    assign mul_unsigned_s = {{W{1'b0}}, a} * {{W{1'b0}}, b};

    // Magnitude pre-processing for signed divide; overflow case 0x8000_0000
    // keeps its bit pattern, which is the correct unsigned magnitude.
    always_comb begin
        is_signed_s = (op == OP_DIV);
        a_neg_s     = is_signed_s & a[W-1];
        b_neg_s     = is_signed_s & b[W-1];
        if (a_neg_s) begin
            dividend_s = {W{1'b0}} - a;
        end else begin
            dividend_s = a;
        end
        if (b_neg_s) begin
            divisor_s = {W{1'b0}} - b;
        end else begin
            divisor_s = b;
        end
    end

    // Sign post-processing on the final divider step.
    always_comb begin
        if (negq_q) begin
            quo_fix_s = {W{1'b0}} - div_quo_s;
        end else begin
            quo_fix_s = div_quo_s;
        end
        if (negr_q) begin
            rem_fix_s = {W{1'b0}} - div_rem_s;
        end else begin
            rem_fix_s = div_rem_s;
        end
    end

    div_iter #(
        .W         (W),
        .DIV_ITERS (DIV_ITERS)
    ) u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_s),
        .dividend  (dividend_s),
        .divisor   (divisor_s),
        .step      (div_step_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s),
        .done      (div_done_s)
    );

    // Sequencing, output selection and result capture.
    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        stall_s     = 1'b0;
        we_s        = 1'b0;
        hilo_s      = {2*W{1'b0}};
        div_start_s = 1'b0;
        div_step_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (e_valid && !flush) begin
                    case (mdu_op_t'(op))
                        OP_MULT: begin
                            we_s   = 1'b1;
                            hilo_s = mul_signed_s;
                        end
                        OP_MULTU: begin
                            we_s   = 1'b1;
                            hilo_s = mul_unsigned_s;
                        end
                        OP_MTHI: begin
                            we_s   = 1'b1;
                            hilo_s = {a, hilo_i[W-1:0]};
                        end
                        OP_MTLO: begin
                            we_s   = 1'b1;
                            hilo_s = {hilo_i[2*W-1:W], a};
                        end
                        OP_DIV, OP_DIVU: begin
                            stall_s = 1'b1;
                            if (b == {W{1'b0}}) begin
                                // Divide by zero bypasses the core entirely.
                                res_d   = {a, {W{1'b1}}};
                                negq_d  = 1'b0;
                                negr_d  = 1'b0;
                                state_d = DONE;
                            end else begin
                                div_start_s = 1'b1;
                                negq_d      = a_neg_s ^ b_neg_s;
                                negr_d      = a_neg_s;
                                state_d     = BUSY;
                            end
                        end
                        default: begin
                            we_s = 1'b0;
                        end
                    endcase
                end else begin
                    we_s = 1'b0;
                end
            end
            BUSY: begin
                stall_s = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    div_step_s = 1'b1;
                    if (div_done_s) begin
                        res_d   = {rem_fix_s, quo_fix_s};
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            DONE: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    we_s   = 1'b1;
                    hilo_s = res_q;
                    if (!stall_i) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            res_q   <= {2*W{1'b0}};
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    // Outputs are forced quiet for as long as reset is asserted.
    always_comb begin
        if (rst) begin
            stall_o = 1'b0;
            we_o    = 1'b0;
            hilo_o  = {2*W{1'b0}};
        end else begin
            stall_o = stall_s;
            we_o    = we_s;
            hilo_o  = hilo_s;
        end
    end

endmodule

// File: tb/tb_hilo_mdu.sv
// Scoreboard bench for hilo_mdu: stimulus pushes expected {HI,LO} writes,
// a negedge monitor pops one entry for every cycle the DUT asserts we_o.
module tb_hilo_mdu;

    import mdu_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           e_valid;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] hilo_i;
    logic           flush;
    logic           stall_i;
    logic           stall_o;
    logic           we_o;
    logic [2*W-1:0] hilo_o;

    logic [63:0]    exp_q[$];
    logic [63:0]    exp_mon;
    int             checks = 0;
    int             errors = 0;

    always #5 clk = ~clk;

    hilo_mdu #(.W(W), .DIV_ITERS(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .e_valid (e_valid),
        .op      (op),
        .a       (a),
        .b       (b),
        .hilo_i  (hilo_i),
        .flush   (flush),
        .stall_i (stall_i),
        .stall_o (stall_o),
        .we_o    (we_o),
        .hilo_o  (hilo_o)
    );

    // Monitor: every write the DUT presents must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && we_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL we_unexpected: got hilo_o=%h, expected no write", hilo_o);
            end else begin
                exp_mon = exp_q.pop_front();
                if (hilo_o !== exp_mon) begin
                    errors++;
                    $display("FAIL hilo_result: got %h, expected %h", hilo_o, exp_mon);
                end
            end
        end
    end

    task automatic check1(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic idle_inputs();
        e_valid = 1'b0;
        op      = OP_NONE;
        a       = '0;
        b       = '0;
        hilo_i  = '0;
    endtask

    // Single-cycle op (MULT/MULTU/MTHI/MTLO); called just after a posedge.
    task automatic quick_run(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                             input logic [63:0] hi, input logic [63:0] exp, input string nm);
        exp_q.push_back(exp);
        e_valid = 1'b1; op = o; a = aa; b = bb; hilo_i = hi;
        @(negedge clk);
        check1({nm, "_stall"}, 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Divide; n_hold>0 keeps stall_i high for n_hold DONE cycles before release.
    task automatic div_run(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                           input logic [63:0] exp, input int exp_stall, input int n_hold,
                           input string nm);
        int  n;
        bit  seen_done;
        n = 0;
        seen_done = 1'b0;
        for (int k = 0; k <= n_hold; k++) exp_q.push_back(exp);
        stall_i = (n_hold > 0);
        e_valid = 1'b1; op = o; a = aa; b = bb;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall_o) begin
                seen_done = 1'b1;
                break;
            end
            n++;
            @(posedge clk); #1;
            idle_inputs();
        end
        check1({nm, "_done_seen"}, 64'(seen_done), 64'd1);
        check1({nm, "_stall_cycles"}, 64'(n), 64'(exp_stall));
        for (int k = 1; k < n_hold; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
        end
        if (n_hold > 0) begin
            @(posedge clk); #1;
            stall_i = 1'b0;
            @(negedge clk);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; stall_i = 1'b0;
        idle_inputs();
        @(negedge clk); @(negedge clk);
        check1("reset_stall", 64'(stall_o), 64'd0);
        check1("reset_we", 64'(we_o), 64'd0);
        check1("reset_hilo", hilo_o, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Multiplies and moves
        quick_run(OP_MULT,  32'hFFFF_FFFD, 32'd5,        64'd0, 64'hFFFF_FFFF_FFFF_FFF1, "mult_neg3x5");
        quick_run(OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'd0, 64'h4000_0000_0000_0000, "mult_minsq");
        quick_run(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, "multu_max");
        quick_run(OP_MTHI,  32'h0000_00AB, 32'd0, 64'h0000_0001_0000_0002, 64'h0000_00AB_0000_0002, "mthi");
        quick_run(OP_MTLO,  32'h0000_0055, 32'd0, 64'h0000_0001_0000_0002, 64'h0000_0001_0000_0055, "mtlo");

        // No write for NONE or an invalid slot
        e_valid = 1'b1; op = OP_NONE; a = 32'd3; b = 32'd4;
        @(negedge clk);
        check1("none_we", 64'(we_o), 64'd0);
        check1("none_hilo", hilo_o, 64'd0);
        @(posedge clk); #1;
        e_valid = 1'b0; op = OP_MULT;
        @(negedge clk);
        check1("invalid_we", 64'(we_o), 64'd0);
        @(posedge clk); #1;
        idle_inputs();

        // Divides
        div_run(OP_DIVU, 32'd100,        32'd7,          {32'd2, 32'd14},               33, 0, "divu_100_7");
        div_run(OP_DIV,  32'hFFFF_FFF9,  32'd2,          64'hFFFF_FFFF_FFFF_FFFD,       33, 0, "div_m7_2");
        div_run(OP_DIV,  32'd7,          32'hFFFF_FFFE,  64'h0000_0001_FFFF_FFFD,       33, 0, "div_7_m2");
        div_run(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  64'h0000_0000_8000_0000,       33, 0, "div_ovf");
        div_run(OP_DIVU, 32'hFFFF_FFFF,  32'h0000_0010,  64'h0000_000F_0FFF_FFFF,       33, 0, "divu_big");
        div_run(OP_DIV,  32'd5,          32'd0,          64'h0000_0005_FFFF_FFFF,        1, 0, "div_5_0");
        div_run(OP_DIV,  32'hFFFF_FFF7,  32'd0,          64'hFFFF_FFF7_FFFF_FFFF,        1, 0, "div_m9_0");
        div_run(OP_DIVU, 32'd100,        32'd7,          {32'd2, 32'd14},               33, 4, "divu_hold");

        // Flush at iteration 10, then MULTU accepted the very next cycle
        e_valid = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        idle_inputs();
        repeat (10) begin @(posedge clk); #1; end
        @(negedge clk);
        check1("flush_busy_stall", 64'(stall_o), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        check1("flush_we", 64'(we_o), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        quick_run(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 64'd0, 64'h0000_0001_FFFF_FFFE, "multu_after_flush");

        // Asynchronous reset in the middle of a division
        e_valid = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        idle_inputs();
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check1("rst_mid_stall", 64'(stall_o), 64'd0);
        check1("rst_mid_we", 64'(we_o), 64'd0);
        check1("rst_mid_hilo", hilo_o, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check1("rst_after_stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        quick_run(OP_MULT, 32'd6, 32'hFFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFD6, "mult_after_rst");

        repeat (3) @(posedge clk);
        #1;
        check1("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
